id_ex_stage: RTL and testbench

- ID/EX pipeline register directly upstream of the vector ALU.
- Decodes the 32-bit instruction from IF/ID and computes the register-file read addresses.
- Applies per-byte, PPP-aware operand forwarding from the EX and WB result buses.
- Registers the operand values and control fields the ALU consumes, and handles stall and flush from the hazard unit.

---
 rtl/isa_pkg.sv | 71 +++++++
 rtl/fwd_operand_mux.sv | 35 +++
 rtl/id_ex_stage.sv | 159 +++++++++++++++
 tb/tb_id_ex_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// ISA constants and decode types shared by the ID/EX stage and its operand muxes.
// Data is big-endian: byte 0 is the most significant byte of a 64-bit value.
package isa_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNC_W  = 6;
  localparam int unsigned PPP_W   = 3;
  localparam int unsigned WW_W    = 2;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned NBYTES  = DATA_W / 8;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD      = 6'b100000,
    OP_STORE     = 6'b100001,
    OP_BRANCH_EZ = 6'b100010,
    OP_BRANCH_NZ = 6'b100011,
    OP_R_ALU     = 6'b101010,
    OP_NOP       = 6'b111100
  } opcode_e;

  localparam logic [FUNC_W-1:0] FUNC_VNOP = 6'b000000;

  typedef enum logic [PPP_W-1:0] {
    PPP_ALL   = 3'b000,
    PPP_UPPER = 3'b001,
    PPP_LOWER = 3'b010,
    PPP_EVEN  = 3'b011,
    PPP_ODD   = 3'b100
  } ppp_e;

  typedef enum logic [WW_W-1:0] {
    WW_8  = 2'b00,
    WW_16 = 2'b01,
    WW_32 = 2'b10,
    WW_64 = 2'b11
  } ww_e;

  // Registered ID/EX payload consumed by the ALU.
  typedef struct packed {
    logic [OP_W-1:0]   op_code;
    logic [FUNC_W-1:0] r_ins;
    logic [WW_W-1:0]   ww;
    logic [REG_AW-1:0] rd;
    logic [PPP_W-1:0]  ppp;
    logic [IMM_W-1:0]  imm;
    logic              reg_wr_en;
    logic              mem_rd;
    logic              mem_wr;
    logic              valid;
    logic [DATA_W-1:0] ra_val;
    logic [DATA_W-1:0] rb_val;
  } id_ex_t;

  // Bit k of the result selects byte k (byte 0 = most significant).
  function automatic logic [NBYTES-1:0] ppp_mask(input logic [PPP_W-1:0] ppp);
    logic [NBYTES-1:0] m;
    case (ppp)
      PPP_ALL:   m = 8'hFF;
      PPP_UPPER: m = 8'h0F;
      PPP_LOWER: m = 8'hF0;
      PPP_EVEN:  m = 8'h55;
      PPP_ODD:   m = 8'hAA;
      default:   m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// Per-byte operand select: EX result, else WB result, else register-file value.
module fwd_operand_mux
  import isa_pkg::*;
(
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] rf_val,
  input  logic              ex_wr_en,
  input  logic [REG_AW-1:0] ex_rD,
  input  logic [PPP_W-1:0]  ex_ppp,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_rD,
  input  logic [PPP_W-1:0]  wb_ppp,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] operand_c
);

  logic [NBYTES-1:0] ex_hit;
  logic [NBYTES-1:0] wb_hit;

  always_comb begin
    ex_hit    = (ex_wr_en && (ex_rD == addr)) ? ppp_mask(ex_ppp) : '0;
    wb_hit    = (wb_wr_en && (wb_rD == addr)) ? ppp_mask(wb_ppp) : '0;
    operand_c = rf_val;
    // Byte k occupies the k-th octet counted from the MSB.
    for (int k = 0; k < int'(NBYTES); k++) begin
      if (ex_hit[k]) begin
        operand_c[DATA_W-1-8*k -: 8] = ex_data[DATA_W-1-8*k -: 8];
      end else if (wb_hit[k]) begin
        operand_c[DATA_W-1-8*k -: 8] = wb_data[DATA_W-1-8*k -: 8];
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decode, register-file addressing, per-byte forwarding
// and the stall/flush-controlled capture of everything the vector ALU consumes.
module id_ex_stage
  import isa_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [INSTR_W-1:0] IF_ID_Instr,
  output logic [REG_AW-1:0]  rf_rA_addr,
  output logic [REG_AW-1:0]  rf_rB_addr,
  input  logic [DATA_W-1:0]  rf_rA_val,
  input  logic [DATA_W-1:0]  rf_rB_val,
  input  logic               ex_wr_en,
  input  logic [REG_AW-1:0]  ex_rD,
  input  logic [PPP_W-1:0]   ex_ppp,
  input  logic [DATA_W-1:0]  ex_data,
  input  logic               wb_wr_en,
  input  logic [REG_AW-1:0]  wb_rD,
  input  logic [PPP_W-1:0]   wb_ppp,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [DATA_W-1:0]  rA_64bit_val,
  output logic [DATA_W-1:0]  rB_64bit_val,
  output logic [OP_W-1:0]    Op_code,
  output logic [FUNC_W-1:0]  R_ins,
  output logic [WW_W-1:0]    WW,
  output logic [REG_AW-1:0]  rD_out,
  output logic [PPP_W-1:0]   PPP_out,
  output logic [IMM_W-1:0]   imm_out,
  output logic               reg_wr_en,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               valid
);

  // Instruction bit 0 (opcode MSB) is vector bit 31.
  logic [OP_W-1:0]   instr_op;
  logic [REG_AW-1:0] instr_rd;
  logic [REG_AW-1:0] instr_ra;
  logic [REG_AW-1:0] instr_rb;
  logic [PPP_W-1:0]  instr_ppp;
  logic [WW_W-1:0]   instr_ww;
  logic [FUNC_W-1:0] instr_func;
  logic [IMM_W-1:0]  instr_imm;

  assign instr_op   = IF_ID_Instr[31:26];
  assign instr_rd   = IF_ID_Instr[25:21];
  assign instr_ra   = IF_ID_Instr[20:16];
  assign instr_rb   = IF_ID_Instr[15:11];
  assign instr_ppp  = IF_ID_Instr[10:8];
  assign instr_ww   = IF_ID_Instr[7:6];
  assign instr_func = IF_ID_Instr[5:0];
  assign instr_imm  = IF_ID_Instr[15:0];

  logic [DATA_W-1:0] fwd_a_c;
  logic [DATA_W-1:0] fwd_b_c;
  id_ex_t            d;
  id_ex_t            q;
  id_ex_t            bubble;

  // Decode; unknown opcodes collapse to NOP.
  always_comb begin
    rf_rA_addr  = instr_ra;
    rf_rB_addr  = instr_rb;
    d           = '0;
    d.op_code   = OP_NOP;
    d.r_ins     = instr_func;
    d.ww        = instr_ww;
    d.rd        = instr_rd;
    d.ppp       = instr_ppp;
    d.ra_val    = fwd_a_c;
    d.rb_val    = fwd_b_c;
    case (instr_op)
      OP_R_ALU: begin
        d.op_code   = instr_op;
        d.valid     = 1'b1;
        d.reg_wr_en = (instr_func != FUNC_VNOP);
      end
      OP_LOAD: begin
        d.op_code   = instr_op;
        d.valid     = 1'b1;
        d.reg_wr_en = 1'b1;
        d.mem_rd    = 1'b1;
        d.imm       = instr_imm;
      end
      OP_STORE: begin
        rf_rA_addr  = instr_rd;
        d.op_code   = instr_op;
        d.valid     = 1'b1;
        d.mem_wr    = 1'b1;
        d.imm       = instr_imm;
      end
      OP_BRANCH_EZ, OP_BRANCH_NZ: begin
        rf_rA_addr  = instr_rd;
        d.op_code   = instr_op;
        d.valid     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    bubble         = '0;
    bubble.op_code = OP_NOP;
  end

  fwd_operand_mux u_fwd_a (
    .addr      (rf_rA_addr),
    .rf_val    (rf_rA_val),
    .ex_wr_en  (ex_wr_en),
    .ex_rD     (ex_rD),
    .ex_ppp    (ex_ppp),
    .ex_data   (ex_data),
    .wb_wr_en  (wb_wr_en),
    .wb_rD     (wb_rD),
    .wb_ppp    (wb_ppp),
    .wb_data   (wb_data),
    .operand_c (fwd_a_c)
  );

  fwd_operand_mux u_fwd_b (
    .addr      (rf_rB_addr),
    .rf_val    (rf_rB_val),
    .ex_wr_en  (ex_wr_en),
    .ex_rD     (ex_rD),
    .ex_ppp    (ex_ppp),
    .ex_data   (ex_data),
    .wb_wr_en  (wb_wr_en),
    .wb_rD     (wb_rD),
    .wb_ppp    (wb_ppp),
    .wb_data   (wb_data),
    .operand_c (fwd_b_c)
  );

  // Priority: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q <= bubble;
    end else if (!stall) begin
      q <= d;
    end
  end

  assign rA_64bit_val = q.ra_val;
  assign rB_64bit_val = q.rb_val;
  assign Op_code      = q.op_code;
  assign R_ins        = q.r_ins;
  assign WW           = q.ww;
  assign rD_out       = q.rd;
  assign PPP_out      = q.ppp;
  assign imm_out      = q.imm;
  assign reg_wr_en    = q.reg_wr_en;
  assign mem_rd       = q.mem_rd;
  assign mem_wr       = q.mem_wr;
  assign valid        = q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stage.
module tb_id_ex_stage;

  localparam logic [5:0] R_ALU = 6'b101010, LOAD = 6'b100000, STORE = 6'b100001;
  localparam logic [5:0] BEZ = 6'b100010, BNZ = 6'b100011, NOP = 6'b111100;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] instr;
  logic [4:0]  rf_rA_addr, rf_rB_addr;
  logic [63:0] rf_rA_val, rf_rB_val;
  logic        ex_wr_en, wb_wr_en;
  logic [4:0]  ex_rD, wb_rD;
  logic [2:0]  ex_ppp, wb_ppp;
  logic [63:0] ex_data, wb_data;
  logic [63:0] rA_64bit_val, rB_64bit_val;
  logic [5:0]  Op_code, R_ins;
  logic [1:0]  WW;
  logic [4:0]  rD_out;
  logic [2:0]  PPP_out;
  logic [15:0] imm_out;
  logic        reg_wr_en, mem_rd, mem_wr, valid;

  logic [63:0] rf_mem [32];
  int checks = 0;
  int failures = 0;

  logic [63:0] e_ra, e_rb;
  logic [5:0]  e_op, e_rins;
  logic [1:0]  e_ww;
  logic [4:0]  e_rd;
  logic [2:0]  e_ppp;
  logic [15:0] e_imm;
  logic        e_wr, e_mrd, e_mwr, e_valid;

  always #5 clk = ~clk;

  assign rf_rA_val = rf_mem[rf_rA_addr];
  assign rf_rB_val = rf_mem[rf_rB_addr];

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .IF_ID_Instr(instr),
    .rf_rA_addr(rf_rA_addr), .rf_rB_addr(rf_rB_addr),
    .rf_rA_val(rf_rA_val), .rf_rB_val(rf_rB_val),
    .ex_wr_en(ex_wr_en), .ex_rD(ex_rD), .ex_ppp(ex_ppp), .ex_data(ex_data),
    .wb_wr_en(wb_wr_en), .wb_rD(wb_rD), .wb_ppp(wb_ppp), .wb_data(wb_data),
    .rA_64bit_val(rA_64bit_val), .rB_64bit_val(rB_64bit_val),
    .Op_code(Op_code), .R_ins(R_ins), .WW(WW), .rD_out(rD_out), .PPP_out(PPP_out),
    .imm_out(imm_out), .reg_wr_en(reg_wr_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .valid(valid)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Byte k of a result is written when the PPP code selects it (byte 0 = MSB).
  function automatic bit byte_on(input logic [2:0] ppp, input int k);
    case (ppp)
      3'd0: return 1'b1;
      3'd1: return k < 4;
      3'd2: return k >= 4;
      3'd3: return (k % 2) == 0;
      3'd4: return (k % 2) == 1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] model_operand(input logic [4:0] a);
    logic [63:0] r;
    r = rf_mem[a];
    for (int k = 0; k < 8; k++) begin
      if (ex_wr_en && ex_rD == a && byte_on(ex_ppp, k))
        r[63-8*k -: 8] = ex_data[63-8*k -: 8];
      else if (wb_wr_en && wb_rD == a && byte_on(wb_ppp, k))
        r[63-8*k -: 8] = wb_data[63-8*k -: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rd, ra, rb,
                                       input logic [2:0] ppp, input logic [1:0] ww,
                                       input logic [5:0] func);
    return {op, rd, ra, rb, ppp, ww, func};
  endfunction

  // Predict the next register state from the inputs currently applied.
  task automatic predict();
    logic [5:0] op;
    logic [4:0] a_addr;
    bit known;
    op = instr[31:26];
    known = (op == R_ALU) || (op == LOAD) || (op == STORE) || (op == BEZ) ||
            (op == BNZ) || (op == NOP);
    a_addr = (op == STORE || op == BEZ || op == BNZ) ? instr[25:21] : instr[20:16];
    check_val("rf_rA_addr", rf_rA_addr, a_addr);
    check_val("rf_rB_addr", rf_rB_addr, instr[15:11]);
    if (reset || flush) begin
      e_op = NOP; e_rins = '0; e_ww = '0; e_rd = '0; e_ppp = '0; e_imm = '0;
      e_wr = 0; e_mrd = 0; e_mwr = 0; e_valid = 0; e_ra = '0; e_rb = '0;
    end else if (!stall) begin
      e_op    = known ? op : NOP;
      e_valid = known && op != NOP;
      e_wr    = (op == R_ALU && instr[5:0] != 6'd0) || op == LOAD;
      e_mrd   = op == LOAD;
      e_mwr   = op == STORE;
      e_imm   = (op == LOAD || op == STORE) ? instr[15:0] : 16'd0;
      e_rd    = instr[25:21];
      e_ppp   = instr[10:8];
      e_ww    = instr[7:6];
      e_rins  = instr[5:0];
      e_ra    = model_operand(a_addr);
      e_rb    = model_operand(instr[15:11]);
    end
  endtask

  task automatic compare_all();
    check_val("rA_val", rA_64bit_val, e_ra);
    check_val("rB_val", rB_64bit_val, e_rb);
    check_val("Op_code", Op_code, e_op);
    check_val("R_ins", R_ins, e_rins);
    check_val("WW", WW, e_ww);
    check_val("rD_out", rD_out, e_rd);
    check_val("PPP_out", PPP_out, e_ppp);
    check_val("imm_out", imm_out, e_imm);
    check_val("reg_wr_en", reg_wr_en, e_wr);
    check_val("mem_rd", mem_rd, e_mrd);
    check_val("mem_wr", mem_wr, e_mwr);
    check_val("valid", valid, e_valid);
  endtask

  // Inputs change at negedge; outputs are compared at the following negedge.
  task automatic tick();
    #1;
    predict();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_fwd();
    ex_wr_en = 0; ex_rD = 0; ex_ppp = 0; ex_data = 0;
    wb_wr_en = 0; wb_rD = 0; wb_ppp = 0; wb_data = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
    reset = 1; stall = 0; flush = 0; instr = '0;
    clear_fwd();
    @(negedge clk);
    tick();
    tick();
    check_val("reset_op", Op_code, NOP);
    check_val("reset_valid", valid, 0);

    reset = 0;
    rf_mem[1] = 64'h0102030405060708;
    rf_mem[2] = 64'h1111111111111111;
    instr = mk_r(R_ALU, 5'd3, 5'd1, 5'd2, 3'd0, 2'b00, 6'b000110);
    tick();
    check_val("vadd_ra", rA_64bit_val, 64'h0102030405060708);
    check_val("vadd_rb", rB_64bit_val, 64'h1111111111111111);
    check_val("vadd_rins", R_ins, 6'b000110);

    ex_wr_en = 1; ex_rD = 1; ex_ppp = 3'b011; ex_data = '1;
    tick();
    check_val("fwd_even_ra", rA_64bit_val, 64'hFF02FF04FF06FF08);

    ex_rD = 2; ex_ppp = 3'b001; ex_data = 64'hAAAAAAAAAAAAAAAA;
    wb_wr_en = 1; wb_rD = 2; wb_ppp = 3'b000; wb_data = 64'hBBBBBBBBBBBBBBBB;
    tick();
    check_val("fwd_prio_rb", rB_64bit_val, 64'hAAAAAAAABBBBBBBB);

    clear_fwd();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      instr = mk_r(LOAD, 5'(i + 4), 5'd9, 5'd10, 3'd2, 2'b01, 6'd7);
      tick();
      check_val("stall_hold_op", Op_code, R_ALU);
    end
    stall = 0;
    tick();
    check_val("after_stall_op", Op_code, LOAD);
    check_val("after_stall_mem_rd", mem_rd, 1);

    stall = 1; flush = 1;
    tick();
    check_val("flush_op", Op_code, NOP);
    check_val("flush_ra", rA_64bit_val, 0);
    stall = 0; flush = 0;
    instr = {STORE, 5'd7, 5'd3, 16'h1234};
    #1 check_val("store_addr", rf_rA_addr, 7);
    tick();
    check_val("store_mem_wr", mem_wr, 1);
    check_val("store_reg_wr", reg_wr_en, 0);

    stall = 1; reset = 1;
    tick();
    check_val("reset_in_stall_valid", valid, 0);
    stall = 0; reset = 0;
    instr = mk_r(6'b000000, 5'd1, 5'd2, 5'd3, 3'd0, 2'b00, 6'd5);
    tick();
    check_val("unknown_valid", valid, 0);
    check_val("unknown_reg_wr", reg_wr_en, 0);

    for (int n = 0; n < 400; n++) begin
      logic [5:0] ops [7];
      ops = '{R_ALU, LOAD, STORE, BEZ, BNZ, NOP, 6'($urandom)};
      reset = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 4) == 0);
      instr = {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom),
               ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom)};
      ex_wr_en = 1'($urandom); ex_rD = 5'($urandom_range(0, 3));
      ex_ppp = 3'($urandom_range(0, 7)); ex_data = {$urandom, $urandom};
      wb_wr_en = 1'($urandom); wb_rD = 5'($urandom_range(0, 3));
      wb_ppp = 3'($urandom_range(0, 7)); wb_data = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rf_mem[$urandom_range(0, 3)] = {$urandom, $urandom};
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
